// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Register scoreboard and pipeline interlock for a simple in-order pipeline.
// Every architectural register r (0..7) has a small down-counter that holds
// the number of cycles left before an outstanding write to r becomes visible
// in the register file. A decode-stage instruction that reads a register with
// a pending write is held (stall). Otherwise it advances (issue). A HALT
// instruction stops issue and waits for all pending writes to retire before
// the block reports halt_done.
//
// Parameters
//   DEPTH       cycles from issue until the write is visible (1..3)
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous active-high reset
//   id_valid    decode stage holds a valid instruction
//   id_rs_sel   first source register select
//   id_rs_used  instruction reads id_rs_sel
//   id_rt_sel   second source register select
//   id_rt_used  instruction reads id_rt_sel
//   id_wr_en    instruction writes a register
//   id_wr_sel   destination register (after the regDest mux, 7 = link)
//   id_halt     decoded instruction is HALT
//   ex_flush    taken branch/jump in execute; kill the decode instruction
//   stall       hold PC and the IF/ID register this cycle
//   issue       decode instruction advances to execute this cycle
//   busy_mask   bit r set while a write to register r is pending
//   halt_done   pipeline drained after HALT (sticky until reset)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_rs_sel,
    input  logic       id_rs_used,
    input  logic [2:0] id_rt_sel,
    input  logic       id_rt_used,
    input  logic       id_wr_en,
    input  logic [2:0] id_wr_sel,
    input  logic       id_halt,
    input  logic       ex_flush,
    output logic       stall,
    output logic       issue,
    output logic [7:0] busy_mask,
    output logic       halt_done
);

    localparam logic [1:0] LOAD_VAL = 2'(DEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_raw;
    logic w_stall;
    logic w_issue;
    logic w_halt_done;
    logic w_load_en;

    // A destination-only match (WAW) is deliberately not part of the hazard:
    // the reload below simply restarts that register's countdown.
    assign w_raw = (id_rs_used & busy_mask[id_rs_sel]) |
                   (id_rt_used & busy_mask[id_rt_sel]);

    // Only an issuing instruction may claim its destination; a stalled,
    // flushed or post-HALT instruction leaves the scoreboard alone.
    assign w_load_en = w_issue & id_wr_en;

    // -------------------------------------------------------------------------
    // Per-register pending-write counters
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cnt
            logic [1:0] r_cnt;

            // A fresh load wins over the decrement of the same register, so a
            // second write to a busy register extends its busy window.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= 2'd0;
                end else if (w_load_en && (id_wr_sel == 3'(gi))) begin
                    r_cnt <= LOAD_VAL;
                end else if (r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end

            assign busy_mask[gi] = (r_cnt != 2'd0);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_issue      = 1'b0;
        w_halt_done  = 1'b0;
        case (r_state)
            RUN: begin
                // A flush kills the decode instruction outright, so it neither
                // stalls nor issues.
                w_stall = id_valid & w_raw & ~ex_flush;
                w_issue = id_valid & ~w_raw & ~ex_flush;
                if (w_issue && id_halt) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_stall = 1'b1;
                if (busy_mask == 8'h00) begin
                    w_state_next = HALTED;
                end
            end
            HALTED: begin
                w_stall     = 1'b1;
                w_halt_done = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign stall     = w_stall;
    assign issue     = w_issue;
    assign halt_done = w_halt_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Table-driven bench for hazard_ctrl (DEPTH = 3). Each vector holds the
// decode-stage inputs for one cycle and the outputs expected during that
// cycle. Expected outputs are queued when a vector is driven and popped when
// the outputs are sampled on the falling edge. Asynchronous reset pulses are
// exercised by hand-written sequences between table segments.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs_sel;
    logic       id_rs_used;
    logic [2:0] id_rt_sel;
    logic       id_rt_used;
    logic       id_wr_en;
    logic [2:0] id_wr_sel;
    logic       id_halt;
    logic       ex_flush;
    logic       stall;
    logic       issue;
    logic [7:0] busy_mask;
    logic       halt_done;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs_sel  (id_rs_sel),
        .id_rs_used (id_rs_used),
        .id_rt_sel  (id_rt_sel),
        .id_rt_used (id_rt_used),
        .id_wr_en   (id_wr_en),
        .id_wr_sel  (id_wr_sel),
        .id_halt    (id_halt),
        .ex_flush   (ex_flush),
        .stall      (stall),
        .issue      (issue),
        .busy_mask  (busy_mask),
        .halt_done  (halt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] rs;
        logic       rsu;
        logic [2:0] rt;
        logic       rtu;
        logic       we;
        logic [2:0] ws;
        logic       halt;
        logic       flush;
        logic       stall;
        logic       issue;
        logic [7:0] busy;
        logic       done;
    } vec_t;

    typedef struct {
        int         idx;
        logic       stall;
        logic       issue;
        logic [7:0] busy;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic valid, input logic [2:0] rs, input logic rsu,
        input logic [2:0] rt, input logic rtu, input logic we,
        input logic [2:0] ws, input logic halt, input logic flush,
        input logic e_stall, input logic e_issue, input logic [7:0] e_busy,
        input logic e_done);
        vec_t v;
        v.valid = valid; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu;
        v.we = we; v.ws = ws; v.halt = halt; v.flush = flush;
        v.stall = e_stall; v.issue = e_issue; v.busy = e_busy; v.done = e_done;
        return v;
    endfunction

    function automatic vec_t idle(input logic [7:0] e_busy);
        return mk(0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, e_busy, 0);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        id_valid   = 1'b0;
        id_rs_sel  = 3'd0;
        id_rs_used = 1'b0;
        id_rt_sel  = 3'd0;
        id_rt_used = 1'b0;
        id_wr_en   = 1'b0;
        id_wr_sel  = 3'd0;
        id_halt    = 1'b0;
        ex_flush   = 1'b0;
    endtask

    task automatic step(input int idx);
        vec_t v;
        exp_t e;
        v = vecs[idx];
        @(posedge clk);
        #1;
        id_valid   = v.valid;
        id_rs_sel  = v.rs;
        id_rs_used = v.rsu;
        id_rt_sel  = v.rt;
        id_rt_used = v.rtu;
        id_wr_en   = v.we;
        id_wr_sel  = v.ws;
        id_halt    = v.halt;
        ex_flush   = v.flush;
        sb.push_back('{idx, v.stall, v.issue, v.busy, v.done});
        @(negedge clk);
        e = sb.pop_front();
        chk("stall",     e.idx, {7'd0, stall},     {7'd0, e.stall});
        chk("issue",     e.idx, {7'd0, issue},     {7'd0, e.issue});
        chk("busy_mask", e.idx, busy_mask,         e.busy);
        chk("halt_done", e.idx, {7'd0, halt_done}, {7'd0, e.done});
        $display("vec %0d: valid=%b rs=%0d/%b rt=%0d/%b wr=%b/%0d halt=%b flush=%b -> stall=%b issue=%b busy=%h done=%b",
                 e.idx, v.valid, v.rs, v.rsu, v.rt, v.rtu, v.we, v.ws, v.halt,
                 v.flush, stall, issue, busy_mask, halt_done);
    endtask

    // Raise rst in the middle of a cycle with idle inputs, check that state
    // clears without waiting for a clock edge, and drop rst before the next
    // rising edge.
    task automatic async_reset_pulse(input string tag);
        #1;
        drive_idle();
        rst = 1'b1;
        #1;
        chk({tag, "_busy"},  -1, busy_mask, 8'h00);
        chk({tag, "_done"},  -1, {7'd0, halt_done}, 8'h00);
        chk({tag, "_stall"}, -1, {7'd0, stall}, 8'h00);
        $display("reset %s: busy=%h done=%b stall=%b", tag, busy_mask, halt_done, stall);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_a;
        int n_b;

        // ---- Segment A: RAW, back-to-back, WAW, reload, flush, halt ----
        vecs.push_back(idle(8'h00));                                          // 0
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 0, 0, 0, 1, 8'h00, 0)); // 1 ADD -> R3
        vecs.push_back(mk(1, 3'd3, 1, 3'd0, 0, 1, 3'd6, 0, 0, 1, 0, 8'h08, 0)); // 2 reads R3
        vecs.push_back(mk(1, 3'd3, 1, 3'd0, 0, 1, 3'd6, 0, 0, 1, 0, 8'h08, 0)); // 3
        vecs.push_back(mk(1, 3'd3, 1, 3'd0, 0, 1, 3'd6, 0, 0, 1, 0, 8'h08, 0)); // 4
        vecs.push_back(mk(1, 3'd3, 1, 3'd0, 0, 1, 3'd6, 0, 0, 0, 1, 8'h00, 0)); // 5 issues
        vecs.push_back(mk(1, 3'd0, 1, 3'd0, 0, 1, 3'd1, 0, 0, 0, 1, 8'h40, 0)); // 6 -> R1
        vecs.push_back(mk(1, 3'd0, 0, 3'd5, 1, 1, 3'd2, 0, 0, 0, 1, 8'h42, 0)); // 7 -> R2
        vecs.push_back(mk(1, 3'd3, 1, 3'd0, 0, 1, 3'd4, 0, 0, 0, 1, 8'h46, 0)); // 8 -> R4
        vecs.push_back(idle(8'h16));                                          // 9
        vecs.push_back(idle(8'h14));                                          // 10
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd4, 0, 0, 0, 1, 8'h10, 0)); // 11 WAW R4
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 0, 0, 0, 1, 8'h10, 0)); // 12 -> R5
        vecs.push_back(idle(8'h30));                                          // 13
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 0, 0, 0, 1, 8'h30, 0)); // 14 -> R5 again
        vecs.push_back(idle(8'h20));                                          // 15
        vecs.push_back(idle(8'h20));                                          // 16
        vecs.push_back(idle(8'h20));                                          // 17
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 0, 0, 1, 8'h00, 0)); // 18 -> R0
        vecs.push_back(mk(1, 3'd0, 1, 3'd0, 0, 1, 3'd3, 0, 1, 0, 0, 8'h01, 0)); // 19 hazard + flush
        vecs.push_back(mk(1, 3'd0, 1, 3'd0, 0, 1, 3'd3, 0, 0, 1, 0, 8'h01, 0)); // 20 hazard
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 0, 1, 0, 0, 8'h01, 0)); // 21 clean + flush
        vecs.push_back(idle(8'h00));                                          // 22 R3 never loaded
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd7, 0, 0, 0, 1, 8'h00, 0)); // 23 -> R7
        vecs.push_back(idle(8'h80));                                          // 24
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 1, 8'h80, 0)); // 25 HALT, cnt7=2
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, 0, 1, 0, 8'h80, 0)); // 26 DRAIN
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, 0, 1, 0, 8'h00, 0)); // 27 DRAIN
        for (int k = 0; k < 11; k++) begin                                    // 28..38 HALTED
            vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, (k == 5), 1, 0, 8'h00, 1));
        end
        n_a = vecs.size();

        // ---- Segment B: after reset in HALTED ----
        vecs.push_back(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, 0, 0, 1, 8'h00, 0));
        vecs.push_back(idle(8'h04));
        n_b = vecs.size();

        // ---- Segment C: after reset with R2 pending ----
        vecs.push_back(mk(1, 3'd2, 1, 3'd2, 1, 0, 3'd0, 0, 0, 0, 1, 8'h00, 0));

        // Power-on reset, checked while rst is still asserted.
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("por_busy",  -1, busy_mask, 8'h00);
        chk("por_done",  -1, {7'd0, halt_done}, 8'h00);
        chk("por_stall", -1, {7'd0, stall}, 8'h00);
        chk("por_issue", -1, {7'd0, issue}, 8'h00);
        $display("reset por: busy=%h done=%b stall=%b issue=%b", busy_mask, halt_done, stall, issue);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < n_a; i++) step(i);
        async_reset_pulse("rst_halted");
        for (int i = n_a; i < n_b; i++) step(i);
        async_reset_pulse("rst_pending");
        for (int i = n_b; i < vecs.size(); i++) step(i);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
